// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes, glitch-filters and deframes 11-bit device frames.
// Latency: keycode/valid update 2 CLK cycles after the fall strobe of the stop bit.
// Backpressure: none; the PS/2 device is free-running and every accepted byte is strobed once.
module ps2_keycode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] keycode,
  output logic       idle,
  output logic       valid,
  output logic       break_flag,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Synchronizer and filter state
  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  // Deframer state
  state_t        state_q, state_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [9:0]    sh_q, sh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    key_q, key_d;
  logic          brk_q, brk_d;
  logic          f0_q, f0_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Two-flop synchronizers; lines idle high so they reset to 1
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2Clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2Data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: follow the synced clock only after FILTER_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Fall strobe coincides with the cycle the filtered clock switches 1->0
  assign fall = filt_q & ~filt_d;

  // Filter registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Deframer next-state, shift/timeout datapath and registered strobes
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    tmo_d   = tmo_q;
    key_d   = key_q;
    brk_d   = brk_q;
    f0_d    = f0_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Only a low data bit on a fall is a start bit
        if (fall && !dat_s2_q) begin
          state_d = RECV;
          bcnt_d  = '0;
          tmo_d   = '0;
          sh_d    = '0;
        end
      end
      RECV: begin
        // A fall takes priority over a simultaneous timeout expiry
        if (fall) begin
          sh_d  = {dat_s2_q, sh_q[9:1]};
          tmo_d = '0;
          if (bcnt_q == 4'd9) begin
            state_d = CHECK;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CHECK: begin
        // sh_q = {stop, parity, data[7:0]}; odd parity over data+parity
        state_d = IDLE;
        if (sh_q[9] && (^sh_q[8:0])) begin
          if (sh_q[7:0] == 8'hF0) begin
            f0_d = 1'b1;
          end else begin
            key_d   = sh_q[7:0];
            brk_d   = f0_q;
            f0_d    = 1'b0;
            valid_d = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Deframer registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      tmo_q   <= '0;
      key_q   <= 8'h00;
      brk_q   <= 1'b0;
      f0_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      tmo_q   <= tmo_d;
      key_q   <= key_d;
      brk_q   <= brk_d;
      f0_q    <= f0_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign keycode    = key_q;
  assign idle       = (state_q == IDLE);
  assign valid      = valid_q;
  assign break_flag = brk_q;
  assign frame_err  = err_q;

endmodule
